core_run_ctrl: RTL
==================

Name: core_run_ctrl

Overview:
- Run/halt sequencer for the HTAR9 core.
- Accepts a start request with a program select and loads the program counter with that program's base address.
- Enables PC advance while the core runs, honours memory stalls, and detects the halt instruction.
- After a fixed pipeline drain it reports done, plus a cycle count and a watchdog timeout flag.
- Sits between the testbench/top-level handshake and the program counter's control inputs.

Parameters:
- PC_W, 16, width of PC and load value.
- N_PROG, 4, number of selectable programs; prog_sel width is clog2(N_PROG).
- PROG_BASE, {16'd0, 16'd128, 16'd256, 16'd384}, packed array of per-program start addresses.
- CNT_W, 32, width of the run cycle counter.
- DRAIN_CYCLES, 2, cycles held after halt before done (in-flight writeback); legal range 0..15.
- TIMEOUT, 65535, RUN-state cycle limit before forced stop.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to launch a program.
- prog_sel  in  clog2(N_PROG)  program index; sampled only when start is accepted.
- halt_insn  in  1  decoded halt/done instruction at current PC.
- stall  in  1  memory busy; PC must hold.
- pc_en  out  1  PC may advance or branch this cycle.
- pc_load  out  1  force PC to pc_load_val at next edge.
- pc_load_val  out  PC_W  load address.
- busy  out  1  high in LOAD, RUN, DRAIN.
- done  out  1  program finished; held until the next accepted start.
- timeout  out  1  run ended by the watchdog; held like done.
- cycle_count  out  CNT_W  cycles spent in RUN; frozen after RUN.

Behaviour:
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- Reset (any state, mid-run included): next edge enters IDLE. All outputs are 0, cycle_count is 0, the drain counter is 0. Reset has priority over every other input.
- IDLE/DONE + start: latch prog_sel, clear done, timeout and cycle_count, go to LOAD.
- start in LOAD, RUN or DRAIN: ignored, with no side effects.
- LOAD (exactly 1 cycle):
  - pc_load=1, pc_load_val=PROG_BASE[latched sel], pc_en=0.
  - Next state RUN.
- Latency: start sampled at edge N; pc_load is high during cycle N+1; PC equals the base after edge N+2; the first pc_en cycle is N+2.
- RUN:
  - pc_en = !stall && !halt_insn (combinational); cycle_count increments every RUN cycle, stalled cycles included.
  - halt_insn && !stall: PC holds on the halt instruction; next state DRAIN, drain counter loaded with DRAIN_CYCLES.
  - halt_insn && stall: halt is not taken; it is retried when stall drops.
  - cycle_count reaching TIMEOUT (counted after increment): next state DONE with timeout=1. This takes priority over a simultaneous halt.
- DRAIN:
  - pc_en=0; the counter decrements each cycle; DONE when it reaches 0.
  - DRAIN_CYCLES=0: DRAIN lasts 1 cycle.
  - stall is ignored here.
- DONE: done=1, busy=0, pc_en=0, pc_load=0; cycle_count frozen.
- pc_load_val is 0 outside LOAD.
- cycle_count saturates at all-ones and never wraps.
- prog_sel ≥ N_PROG: treated as index 0.

Decomposition:
- Package core_ctrl_pkg holds:
  - the state enum (run_state_t: IDLE, LOAD, RUN, DRAIN, DONE);
  - default PC_W;
  - default PROG_BASE constants;
  - the DRAIN_CYCLES default.
- One sub-module, sat_cycle_counter (clear, enable, saturating CNT_W output, terminal-count compare against TIMEOUT), instanced once.
- The FSM and load mux stay in core_run_ctrl.

Test Plan:
- Reset, then start with prog_sel=1:
  - pc_load high for one cycle with pc_load_val=128;
  - busy=1 from the following cycle;
  - pc_en=1 two cycles after start.
- RUN for 10 cycles with stall high in cycles 3-4, then halt_insn:
  - pc_en low during the stall and on the halt cycle;
  - done rises exactly DRAIN_CYCLES+1 cycles after halt;
  - cycle_count=11.
- halt_insn and stall together for 3 cycles, then stall drops:
  - DRAIN entered only after stall=0;
  - no done before then.
- Pulse start during RUN and DRAIN: no reload, cycle_count not cleared, done timing unchanged.
- TIMEOUT=20, halt_insn never asserted:
  - DONE with timeout=1 and cycle_count=20;
  - a new start clears both flags and reloads PC.
- Assert reset mid-RUN:
  - next cycle state IDLE, all outputs 0;
  - a subsequent start with prog_sel=3 yields pc_load_val=384.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the core run/halt sequencer.
// Pure declarations; no latency.
// No flow control; constants only.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } run_state_t;

  localparam int DEF_PC_W         = 16;
  localparam int DEF_N_PROG       = 4;
  localparam int DEF_DRAIN_CYCLES = 2;

  // Index 0 is the leftmost entry, so program k starts at entry k as listed.
  localparam logic [0:DEF_N_PROG-1][DEF_PC_W-1:0] DEF_PROG_BASE =
    {16'd0, 16'd128, 16'd256, 16'd384};

endpackage

// File: rtl/core_run_ctrl_sat_cycle_counter.sv
// Saturating cycle counter with terminal-count compare against TIMEOUT.
// count updates one edge after enable; tc is combinational on the post-increment value.
// No backpressure; clear wins over enable and the count never wraps.
module sat_cycle_counter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_inc;

  // Next value with saturation at all-ones.
  always_comb begin
    count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
  end

  // Terminal count: this enabled cycle brings the count to the limit.
  always_comb begin
    tc = enable && (count_inc >= LIMIT);
  end

  // Count register: cleared on reset or a new launch, advanced while enabled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt sequencer: loads the PC with a program base, gates PC advance, drains on halt.
// Start to pc_load is 1 cycle; first pc_en 2 cycles after start; done DRAIN_CYCLES+1 after halt.
// stall holds pc_en low and defers halt; start is ignored while busy.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int                               PC_W         = DEF_PC_W,
  parameter int                               N_PROG       = DEF_N_PROG,
  parameter logic [0:N_PROG-1][PC_W-1:0]      PROG_BASE    = DEF_PROG_BASE,
  parameter int                               CNT_W        = 32,
  parameter int                               DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int                               TIMEOUT      = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(N_PROG)-1:0]  prog_sel,
  input  logic                       halt_insn,
  input  logic                       stall,
  output logic                       pc_en,
  output logic                       pc_load,
  output logic [PC_W-1:0]            pc_load_val,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int         SEL_W      = $clog2(N_PROG);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  run_state_t       state;
  run_state_t       state_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_idx;
  logic [3:0]       drain_cnt;
  logic             timeout_q;
  logic             accept;
  logic             halt_take;
  logic             cnt_en;
  logic             cnt_tc;

  // A launch is only honoured when nothing is in flight.
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    halt_take = halt_insn && !stall;
    cnt_en    = (state == RUN);
  end

  sat_cycle_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (cnt_en),
    .count  (cycle_count),
    .tc     (cnt_tc)
  );

  // State register; reset forces IDLE regardless of anything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the watchdog beats a simultaneous halt.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (cnt_tc) begin
          state_nxt = DONE;
        end else if (halt_take) begin
          state_nxt = DRAIN;
        end
      end
      // A zero drain length still spends one cycle here.
      DRAIN:   if (drain_cnt <= 4'd1) state_nxt = DONE;
      DONE:    if (accept) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Launch bookkeeping: program select, drain countdown, watchdog flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= '0;
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        sel_q     <= prog_sel;
        timeout_q <= 1'b0;
      end
      if ((state == RUN) && cnt_tc) begin
        timeout_q <= 1'b1;
      end
      if ((state == RUN) && halt_take && !cnt_tc) begin
        drain_cnt <= DRAIN_INIT;
      end else if ((state == DRAIN) && (drain_cnt != 4'd0)) begin
        drain_cnt <= drain_cnt - 4'd1;
      end
    end
  end

  // Out-of-range selects fall back to program 0.
  always_comb begin
    sel_idx = (int'(sel_q) < N_PROG) ? sel_q : '0;
  end

  // Outputs decoded from state; pc_en follows stall/halt combinationally in RUN.
  always_comb begin
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    case (state)
      LOAD: begin
        pc_load     = 1'b1;
        pc_load_val = PROG_BASE[sel_idx];
        busy        = 1'b1;
      end
      RUN: begin
        pc_en = !stall && !halt_insn;
        busy  = 1'b1;
      end
      DRAIN: busy = 1'b1;
      DONE: begin
        done    = 1'b1;
        timeout = timeout_q;
      end
      default: ;
    endcase
  end

endmodule
